// File: rtl/pipeline_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_ctrl_if
//  Description : Signal bundle between the 5-stage MIPS datapath and the
//                stall/flush sequencer. Hazard-detection inputs and the
//                pipeline-control outputs travel together.
//  Revision    : 1.0  initial release
// ============================================================================
interface pipeline_hazard_ctrl_if #(
  parameter int REG_AW = 5
);

  // Decode-stage operand information
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rs;
  logic              id_uses_rt;

  // Execute-stage producer information
  logic [REG_AW-1:0] ex_rd;
  logic              ex_mem_read;
  logic              ex_branch_taken;

  // Control-flow and multiply/divide decode flags
  logic              id_jump;
  logic              id_mdu_start;
  logic              id_mdu_read;

  // Pipeline control returned to the datapath
  logic              pc_en;
  logic              ifid_en;
  logic              ifid_flush;
  logic              idex_flush;
  logic              mdu_busy;

  // Datapath side: supplies hazard inputs, consumes control
  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt,
    output ex_rd, ex_mem_read, ex_branch_taken,
    output id_jump, id_mdu_start, id_mdu_read,
    input  pc_en, ifid_en, ifid_flush, idex_flush, mdu_busy
  );

  // Sequencer side: consumes hazard inputs, produces control
  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt,
    input  ex_rd, ex_mem_read, ex_branch_taken,
    input  id_jump, id_mdu_start, id_mdu_read,
    output pc_en, ifid_en, ifid_flush, idex_flush, mdu_busy
  );

endinterface : pipeline_hazard_ctrl_if
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_ctrl
//  Description : Stall/flush sequencer for a 5-stage MIPS pipeline.
//                Detects load-use hazards, taken branches and jumps, and
//                tracks a multi-cycle mult/div unit with a two-state FSM
//                plus down-counter. Drives PC/IF-ID enables and flushes.
//  Revision    : 1.0  initial release
// ============================================================================
module pipeline_hazard_ctrl #(
  parameter int MDU_LAT = 32,
  parameter int REG_AW  = 5
) (
  input  wire logic               clk,
  input  wire logic               rst,     // synchronous, active-low
  pipeline_hazard_ctrl_if.slave   hz_if
);

  // Counter must hold MDU_LAT-1; keep at least one bit for MDU_LAT == 1
  localparam int CNT_W = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;
  localparam logic [CNT_W-1:0] c_CNT_INIT = CNT_W'(MDU_LAT - 1);
  localparam logic [CNT_W-1:0] c_CNT_ZERO = '0;
  localparam logic [REG_AW-1:0] c_REG_ZERO = '0;

  typedef enum logic [0:0] {
    S_RUN  = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic w_lu;
  logic w_mh;
  logic w_stall;
  logic w_rs_hit;
  logic w_rt_hit;

  logic w_pc_en;
  logic w_ifid_en;
  logic w_ifid_flush;
  logic w_idex_flush;
  logic w_mdu_busy;

  // Load-use hazard: a load in EX writes a non-zero register that ID reads
  always_comb begin
    w_rs_hit = hz_if.id_uses_rs && (hz_if.id_rs == hz_if.ex_rd);
    w_rt_hit = hz_if.id_uses_rt && (hz_if.id_rt == hz_if.ex_rd);
    w_lu     = hz_if.ex_mem_read && (hz_if.ex_rd != c_REG_ZERO)
               && (w_rs_hit || w_rt_hit);
    // Any MDU access while a mult/div is in flight must wait for it
    w_mh     = (r_state == S_BUSY) && (hz_if.id_mdu_read || hz_if.id_mdu_start);
    w_stall  = w_lu || w_mh;
  end

  // State and countdown registers; reset returns to idle with a cleared count
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_RUN;
      r_cnt   <= c_CNT_ZERO;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic: issue from RUN, count down in BUSY
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_RUN: begin
        // A start held back by load-use is taken once the hazard clears;
        // a wrong-path start under a taken branch is discarded
        if (hz_if.id_mdu_start && !w_lu && !hz_if.ex_branch_taken) begin
          w_state_nxt = S_BUSY;
          w_cnt_nxt   = c_CNT_INIT;
        end
      end
      S_BUSY: begin
        // Taken branches do not abort: the issued mult/div is committed
        if (r_cnt != c_CNT_ZERO) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      default: begin
        w_state_nxt = S_RUN;
        w_cnt_nxt   = c_CNT_ZERO;
      end
    endcase
  end

  // Output priority: reset > branch > stall > jump > normal
  always_comb begin
    w_pc_en      = 1'b1;
    w_ifid_en    = 1'b1;
    w_ifid_flush = 1'b0;
    w_idex_flush = 1'b0;
    w_mdu_busy   = (r_state == S_BUSY);
    if (!rst) begin
      w_pc_en      = 1'b0;
      w_ifid_en    = 1'b0;
      w_ifid_flush = 1'b1;
      w_idex_flush = 1'b1;
      w_mdu_busy   = 1'b0;
    end else if (hz_if.ex_branch_taken) begin
      // ID holds a wrong-path instruction, so any stall it causes is moot
      w_ifid_flush = 1'b1;
      w_idex_flush = 1'b1;
    end else if (w_stall) begin
      // Freeze fetch/decode and inject a bubble; a pending jump retries
      w_pc_en      = 1'b0;
      w_ifid_en    = 1'b0;
      w_idex_flush = 1'b1;
    end else if (hz_if.id_jump) begin
      w_ifid_flush = 1'b1;
    end
  end

  assign hz_if.pc_en      = w_pc_en;
  assign hz_if.ifid_en    = w_ifid_en;
  assign hz_if.ifid_flush = w_ifid_flush;
  assign hz_if.idex_flush = w_idex_flush;
  assign hz_if.mdu_busy   = w_mdu_busy;

endmodule : pipeline_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_hazard_ctrl
//  Description : Directed self-checking bench for pipeline_hazard_ctrl
//                with MDU_LAT = 4. Outputs are compared as the packed
//                vector {pc_en, ifid_en, ifid_flush, idex_flush, mdu_busy}.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

  localparam int MDU_LAT = 4;
  localparam int REG_AW  = 5;

  // Expected output patterns {pc_en, ifid_en, ifid_flush, idex_flush, mdu_busy}
  localparam logic [4:0] c_RESET  = 5'b00110;
  localparam logic [4:0] c_NORMAL = 5'b11000;
  localparam logic [4:0] c_STALL  = 5'b00010;
  localparam logic [4:0] c_BRANCH = 5'b11110;
  localparam logic [4:0] c_JUMP   = 5'b11100;
  localparam logic [4:0] c_BUSY   = 5'b11001;
  localparam logic [4:0] c_BSTALL = 5'b00011;
  localparam logic [4:0] c_BBRNCH = 5'b11111;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pipeline_hazard_ctrl_if #(.REG_AW(REG_AW)) bus ();

  pipeline_hazard_ctrl #(
    .MDU_LAT (MDU_LAT),
    .REG_AW  (REG_AW)
  ) u_dut (
    .clk   (clk),
    .rst   (rst),
    .hz_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] w_obs;
  assign w_obs = {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_flush, bus.mdu_busy};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.id_rs           = '0;
    bus.id_rt           = '0;
    bus.id_uses_rs      = 1'b0;
    bus.id_uses_rt      = 1'b0;
    bus.ex_rd           = '0;
    bus.ex_mem_read     = 1'b0;
    bus.ex_branch_taken = 1'b0;
    bus.id_jump         = 1'b0;
    bus.id_mdu_start    = 1'b0;
    bus.id_mdu_read     = 1'b0;
  endtask

  task automatic lu_hit();
    bus.ex_mem_read = 1'b1;
    bus.ex_rd       = 5'd8;
    bus.id_rs       = 5'd8;
    bus.id_uses_rs  = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [4:0] exp);
    #1;
    checks++;
    assert (w_obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, w_obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    clr();
    tick();
    tick();
    chk("reset_idle", c_RESET);
    lu_hit();
    chk("reset_with_hazard", c_RESET);

    clr();
    rst = 1'b1;
    tick();
    chk("normal", c_NORMAL);

    // Load-use on rs: exactly one stall cycle
    lu_hit();
    chk("lu_rs_hit", c_STALL);
    tick();
    clr();
    chk("lu_cleared", c_NORMAL);

    // Load into $zero never hazards
    lu_hit();
    bus.ex_rd = 5'd0;
    bus.id_rs = 5'd0;
    chk("lu_zero_reg", c_NORMAL);

    // rs unused, rt reads a different register
    tick();
    lu_hit();
    bus.id_uses_rs = 1'b0;
    bus.id_uses_rt = 1'b1;
    bus.id_rt      = 5'd9;
    chk("lu_rs_unused", c_NORMAL);
    bus.id_rt = 5'd8;
    chk("lu_rt_hit", c_STALL);

    // Taken branch overrides a load-use stall and drops a wrong-path mult
    tick();
    clr();
    lu_hit();
    bus.ex_branch_taken = 1'b1;
    chk("branch_over_lu", c_BRANCH);
    bus.id_mdu_start = 1'b1;
    chk("branch_with_mdu", c_BRANCH);
    tick();
    clr();
    chk("branch_no_busy", c_NORMAL);

    // Jump blocked by load-use, then taken the next cycle
    lu_hit();
    bus.id_jump = 1'b1;
    chk("jump_lu_stall", c_STALL);
    tick();
    clr();
    bus.id_jump = 1'b1;
    chk("jump_retry", c_JUMP);

    // Mult in cycle 0, mflo from cycle 2: busy 1..4, stall 2..4, free at 5
    tick();
    clr();
    bus.id_mdu_start = 1'b1;
    chk("mdu_c0_issue", c_NORMAL);
    tick();
    clr();
    chk("mdu_c1_busy", c_BUSY);
    tick();
    bus.id_mdu_read = 1'b1;
    chk("mdu_c2_stall", c_BSTALL);
    tick();
    chk("mdu_c3_stall", c_BSTALL);
    tick();
    chk("mdu_c4_stall", c_BSTALL);
    tick();
    chk("mdu_c5_free", c_NORMAL);

    // Mult blocked by load-use, accepted once the hazard clears
    tick();
    clr();
    lu_hit();
    bus.id_mdu_start = 1'b1;
    chk("mdu_lu_block", c_STALL);
    tick();
    clr();
    bus.id_mdu_start = 1'b1;
    chk("mdu_accept", c_NORMAL);
    tick();
    clr();
    chk("mdu_a1_busy", c_BUSY);

    // Taken branch in BUSY does not abort the count
    tick();
    bus.ex_branch_taken = 1'b1;
    chk("mdu_a2_branch", c_BBRNCH);

    // Back-to-back mult stalls until RUN, then issues
    tick();
    clr();
    bus.id_mdu_start = 1'b1;
    chk("mdu_a3_b2b_stall", c_BSTALL);
    tick();
    chk("mdu_a4_b2b_stall", c_BSTALL);
    tick();
    chk("mdu_a5_b2b_issue", c_NORMAL);
    tick();
    clr();
    chk("mdu_a6_busy", c_BUSY);

    // Reset for one cycle with cnt=2, then no residual busy or stall
    tick();
    rst = 1'b0;
    chk("mid_busy_reset", c_RESET);
    tick();
    rst = 1'b1;
    chk("post_reset_idle", c_NORMAL);
    bus.id_mdu_read = 1'b1;
    chk("post_reset_mflo", c_NORMAL);
    tick();
    clr();
    chk("post_reset_hold", c_NORMAL);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pipeline_hazard_ctrl
`default_nettype wire
